// File: rtl/config_broadcaster.sv
// config_broadcaster: captures one clamped shadow copy of the acquisition/trigger
// configuration and commits it into each enabled channel's registers while that channel is idle.
module config_broadcaster #(
  parameter int CHANNEL_NUM                 = 4,
  parameter int ADC_RESOLUTION_WIDTH        = 12,
  parameter int MAX_PRE_ACQUISITION_LENGTH  = 2,
  parameter int MAX_POST_ACQUISITION_LENGTH = 2,
  localparam int PW = $clog2(MAX_PRE_ACQUISITION_LENGTH) + 1,
  localparam int QW = $clog2(MAX_POST_ACQUISITION_LENGTH) + 1,
  localparam int HW = ADC_RESOLUTION_WIDTH + 1
) (
  input  logic                        CLK,
  input  logic                        RESETN,
  input  logic                        SET_CONFIG,
  input  logic                        STOP,
  input  logic [CHANNEL_NUM-1:0]      CHANNEL_ENABLE,
  input  logic [CHANNEL_NUM-1:0]      CH_BUSY,
  input  logic [1:0]                  ACQUIRE_MODE,
  input  logic [3:0]                  TRIGGER_TYPE,
  input  logic signed [15:0]          RISING_EDGE_THRESHOLD,
  input  logic signed [15:0]          FALLING_EDGE_THRESHOLD,
  input  logic signed [15:0]          L_GAIN_BASELINE,
  input  logic signed [HW-1:0]        H_GAIN_BASELINE,
  input  logic [PW-1:0]               PRE_ACQUISITION_LENGTH,
  input  logic [QW-1:0]               POST_ACQUISITION_LENGTH,
  input  logic [15:0]                 MAX_TRIGGER_LENGTH,
  output logic [CHANNEL_NUM*2-1:0]    ACQUIRE_MODE_CH,
  output logic [CHANNEL_NUM*4-1:0]    TRIGGER_TYPE_CH,
  output logic [CHANNEL_NUM*16-1:0]   RISING_EDGE_THRESHOLD_CH,
  output logic [CHANNEL_NUM*16-1:0]   FALLING_EDGE_THRESHOLD_CH,
  output logic [CHANNEL_NUM*16-1:0]   L_GAIN_BASELINE_CH,
  output logic [CHANNEL_NUM*HW-1:0]   H_GAIN_BASELINE_CH,
  output logic [CHANNEL_NUM*PW-1:0]   PRE_ACQUISITION_LENGTH_CH,
  output logic [CHANNEL_NUM*QW-1:0]   POST_ACQUISITION_LENGTH_CH,
  output logic [CHANNEL_NUM*16-1:0]   MAX_TRIGGER_LENGTH_CH,
  output logic [CHANNEL_NUM-1:0]      SET_CONFIG_CH,
  output logic [CHANNEL_NUM-1:0]      STOP_CH,
  output logic                        BUSY,
  output logic                        CONFIG_DONE,
  output logic                        CONFIG_CLAMPED
);
  typedef enum logic [1:0] {IDLE, CAPTURE, DIST} state_t;
  localparam logic [PW-1:0] PRE_MAX  = PW'(MAX_PRE_ACQUISITION_LENGTH);
  localparam logic [QW-1:0] POST_MAX = QW'(MAX_POST_ACQUISITION_LENGTH);
  state_t                   state_q;
  logic                     set_q, arm_q, busy_q, done_q, clamped_q;
  logic [CHANNEL_NUM-1:0]   mask_q, pend_q, set_ch_q, stop_q;
  logic [1:0]               sh_acq_q;
  logic [3:0]               sh_trig_q;
  logic [15:0]              sh_rise_q, sh_fall_q, sh_lg_q, sh_mtl_q;
  logic [HW-1:0]            sh_hg_q;
  logic [PW-1:0]            sh_pre_q;
  logic [QW-1:0]            sh_post_q;
  logic [CHANNEL_NUM*2-1:0]  acq_q;
  logic [CHANNEL_NUM*4-1:0]  trig_q;
  logic [CHANNEL_NUM*16-1:0] rise_q, fall_q, lg_q, mtl_q;
  logic [CHANNEL_NUM*HW-1:0] hg_q;
  logic [CHANNEL_NUM*PW-1:0] pre_q;
  logic [CHANNEL_NUM*QW-1:0] post_q;
  logic                     edge_w, pre_ovr, post_ovr, mtl_zero, fall_ovr, clamp_w;
  logic [CHANNEL_NUM-1:0]   commit_w;
  // arm_q blocks a level already high out of reset from counting as an edge
  assign edge_w   = SET_CONFIG & ~set_q & arm_q;
  assign pre_ovr  = PRE_ACQUISITION_LENGTH > PRE_MAX;
  assign post_ovr = POST_ACQUISITION_LENGTH > POST_MAX;
  assign mtl_zero = MAX_TRIGGER_LENGTH == 16'd0;
  assign fall_ovr = FALLING_EDGE_THRESHOLD > RISING_EDGE_THRESHOLD;
  assign clamp_w  = pre_ovr | post_ovr | mtl_zero | fall_ovr;
  assign commit_w = (state_q == DIST && !STOP && !edge_w) ? pend_q & ~CH_BUSY : '0;
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      state_q   <= IDLE;
      set_q     <= 1'b0;
      arm_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
      mask_q    <= '0;
      pend_q    <= '0;
      set_ch_q  <= '0;
      stop_q    <= '0;
      sh_acq_q  <= '0;
      sh_trig_q <= '0;
      sh_rise_q <= '0;
      sh_fall_q <= '0;
      sh_lg_q   <= '0;
      sh_hg_q   <= '0;
      sh_pre_q  <= '0;
      sh_post_q <= '0;
      sh_mtl_q  <= '0;
    end else begin
      set_q    <= SET_CONFIG;
      arm_q    <= arm_q | ~SET_CONFIG;
      stop_q   <= {CHANNEL_NUM{STOP}} & mask_q;
      set_ch_q <= commit_w;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: if (edge_w && !STOP) begin
          state_q <= CAPTURE;
          busy_q  <= 1'b1;
        end
        CAPTURE: begin
          sh_acq_q  <= ACQUIRE_MODE;
          sh_trig_q <= TRIGGER_TYPE;
          sh_rise_q <= RISING_EDGE_THRESHOLD;
          sh_fall_q <= fall_ovr ? RISING_EDGE_THRESHOLD : FALLING_EDGE_THRESHOLD;
          sh_lg_q   <= L_GAIN_BASELINE;
          sh_hg_q   <= H_GAIN_BASELINE;
          sh_pre_q  <= pre_ovr ? PRE_MAX : PRE_ACQUISITION_LENGTH;
          sh_post_q <= post_ovr ? POST_MAX : POST_ACQUISITION_LENGTH;
          sh_mtl_q  <= mtl_zero ? 16'd1 : MAX_TRIGGER_LENGTH;
          mask_q    <= CHANNEL_ENABLE;
          pend_q    <= CHANNEL_ENABLE;
          clamped_q <= clamp_w;
          state_q   <= DIST;
        end
        DIST: if (STOP) begin
          pend_q  <= '0;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else if (edge_w) begin
          state_q <= CAPTURE;
        end else if (pend_q == '0) begin
          done_q  <= 1'b1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else begin
          pend_q <= pend_q & ~commit_w;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      acq_q  <= '0;
      trig_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      lg_q   <= '0;
      hg_q   <= '0;
      pre_q  <= '0;
      post_q <= '0;
      mtl_q  <= '0;
    end else begin
      for (int i = 0; i < CHANNEL_NUM; i++)
        if (commit_w[i]) begin
          acq_q[i*2 +: 2]    <= sh_acq_q;
          trig_q[i*4 +: 4]   <= sh_trig_q;
          rise_q[i*16 +: 16] <= sh_rise_q;
          fall_q[i*16 +: 16] <= sh_fall_q;
          lg_q[i*16 +: 16]   <= sh_lg_q;
          hg_q[i*HW +: HW]   <= sh_hg_q;
          pre_q[i*PW +: PW]  <= sh_pre_q;
          post_q[i*QW +: QW] <= sh_post_q;
          mtl_q[i*16 +: 16]  <= sh_mtl_q;
        end
    end
  assign ACQUIRE_MODE_CH            = acq_q;
  assign TRIGGER_TYPE_CH            = trig_q;
  assign RISING_EDGE_THRESHOLD_CH   = rise_q;
  assign FALLING_EDGE_THRESHOLD_CH  = fall_q;
  assign L_GAIN_BASELINE_CH         = lg_q;
  assign H_GAIN_BASELINE_CH         = hg_q;
  assign PRE_ACQUISITION_LENGTH_CH  = pre_q;
  assign POST_ACQUISITION_LENGTH_CH = post_q;
  assign MAX_TRIGGER_LENGTH_CH      = mtl_q;
  assign SET_CONFIG_CH              = set_ch_q;
  assign STOP_CH                    = stop_q;
  assign BUSY                       = busy_q;
  assign CONFIG_DONE                = done_q;
  assign CONFIG_CLAMPED             = clamped_q;
endmodule

// File: tb/tb_config_broadcaster.sv
// tb_config_broadcaster: directed sequence with a commit scoreboard for config_broadcaster.
module tb_config_broadcaster;
  typedef struct packed {
    logic [1:0]  acq;
    logic [3:0]  trig;
    logic [15:0] rise;
    logic [15:0] fall;
    logic [15:0] lg;
    logic [12:0] hg;
    logic [1:0]  pre;
    logic [1:0]  post;
    logic [15:0] mtl;
  } cfg_t;
  typedef struct packed {
    logic [3:0] mask;
    cfg_t       cfg;
  } rec_t;
  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        SET_CONFIG = 1'b0;
  logic        STOP = 1'b0;
  logic [3:0]  CHANNEL_ENABLE = '0;
  logic [3:0]  CH_BUSY = '0;
  logic [1:0]  ACQUIRE_MODE = '0;
  logic [3:0]  TRIGGER_TYPE = '0;
  logic [15:0] RISING_EDGE_THRESHOLD = '0;
  logic [15:0] FALLING_EDGE_THRESHOLD = '0;
  logic [15:0] L_GAIN_BASELINE = '0;
  logic [12:0] H_GAIN_BASELINE = '0;
  logic [1:0]  PRE_ACQUISITION_LENGTH = '0;
  logic [1:0]  POST_ACQUISITION_LENGTH = '0;
  logic [15:0] MAX_TRIGGER_LENGTH = '0;
  logic [7:0]  ACQUIRE_MODE_CH;
  logic [15:0] TRIGGER_TYPE_CH;
  logic [63:0] RISING_EDGE_THRESHOLD_CH, FALLING_EDGE_THRESHOLD_CH, L_GAIN_BASELINE_CH, MAX_TRIGGER_LENGTH_CH;
  logic [51:0] H_GAIN_BASELINE_CH;
  logic [7:0]  PRE_ACQUISITION_LENGTH_CH, POST_ACQUISITION_LENGTH_CH;
  logic [3:0]  SET_CONFIG_CH, STOP_CH;
  logic        BUSY, CONFIG_DONE, CONFIG_CLAMPED;
  int          vectors = 0;
  int          errs = 0;
  rec_t        exp_q[$];
  config_broadcaster dut (
    .CLK(CLK), .RESETN(RESETN), .SET_CONFIG(SET_CONFIG), .STOP(STOP),
    .CHANNEL_ENABLE(CHANNEL_ENABLE), .CH_BUSY(CH_BUSY),
    .ACQUIRE_MODE(ACQUIRE_MODE), .TRIGGER_TYPE(TRIGGER_TYPE),
    .RISING_EDGE_THRESHOLD(RISING_EDGE_THRESHOLD), .FALLING_EDGE_THRESHOLD(FALLING_EDGE_THRESHOLD),
    .L_GAIN_BASELINE(L_GAIN_BASELINE), .H_GAIN_BASELINE(H_GAIN_BASELINE),
    .PRE_ACQUISITION_LENGTH(PRE_ACQUISITION_LENGTH), .POST_ACQUISITION_LENGTH(POST_ACQUISITION_LENGTH),
    .MAX_TRIGGER_LENGTH(MAX_TRIGGER_LENGTH),
    .ACQUIRE_MODE_CH(ACQUIRE_MODE_CH), .TRIGGER_TYPE_CH(TRIGGER_TYPE_CH),
    .RISING_EDGE_THRESHOLD_CH(RISING_EDGE_THRESHOLD_CH), .FALLING_EDGE_THRESHOLD_CH(FALLING_EDGE_THRESHOLD_CH),
    .L_GAIN_BASELINE_CH(L_GAIN_BASELINE_CH), .H_GAIN_BASELINE_CH(H_GAIN_BASELINE_CH),
    .PRE_ACQUISITION_LENGTH_CH(PRE_ACQUISITION_LENGTH_CH), .POST_ACQUISITION_LENGTH_CH(POST_ACQUISITION_LENGTH_CH),
    .MAX_TRIGGER_LENGTH_CH(MAX_TRIGGER_LENGTH_CH),
    .SET_CONFIG_CH(SET_CONFIG_CH), .STOP_CH(STOP_CH), .BUSY(BUSY),
    .CONFIG_DONE(CONFIG_DONE), .CONFIG_CLAMPED(CONFIG_CLAMPED)
  );
  always #5 CLK = ~CLK;
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic cfg_t clampf(input cfg_t c);
    cfg_t r = c;
    if (r.pre > 2'd2) r.pre = 2'd2;
    if (r.post > 2'd2) r.post = 2'd2;
    if (r.mtl == 16'd0) r.mtl = 16'd1;
    if ($signed(r.fall) > $signed(r.rise)) r.fall = r.rise;
    return r;
  endfunction
  function automatic cfg_t slice(input int i);
    cfg_t c;
    c.acq  = ACQUIRE_MODE_CH[i*2 +: 2];
    c.trig = TRIGGER_TYPE_CH[i*4 +: 4];
    c.rise = RISING_EDGE_THRESHOLD_CH[i*16 +: 16];
    c.fall = FALLING_EDGE_THRESHOLD_CH[i*16 +: 16];
    c.lg   = L_GAIN_BASELINE_CH[i*16 +: 16];
    c.hg   = H_GAIN_BASELINE_CH[i*13 +: 13];
    c.pre  = PRE_ACQUISITION_LENGTH_CH[i*2 +: 2];
    c.post = POST_ACQUISITION_LENGTH_CH[i*2 +: 2];
    c.mtl  = MAX_TRIGGER_LENGTH_CH[i*16 +: 16];
    return c;
  endfunction
  task automatic apply(input cfg_t c);
    ACQUIRE_MODE = c.acq;
    TRIGGER_TYPE = c.trig;
    RISING_EDGE_THRESHOLD = c.rise;
    FALLING_EDGE_THRESHOLD = c.fall;
    L_GAIN_BASELINE = c.lg;
    H_GAIN_BASELINE = c.hg;
    PRE_ACQUISITION_LENGTH = c.pre;
    POST_ACQUISITION_LENGTH = c.post;
    MAX_TRIGGER_LENGTH = c.mtl;
  endtask
  task automatic expect_commit(input logic [3:0] mask, input cfg_t c);
    rec_t r;
    r.mask = mask;
    r.cfg = clampf(c);
    exp_q.push_back(r);
  endtask
  task automatic check_commit(input string tag, input int exp_wait);
    int n = 0;
    rec_t r;
    while (SET_CONFIG_CH == 4'd0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(exp_wait));
    if (SET_CONFIG_CH == 4'd0) return;
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected"}, 128'(SET_CONFIG_CH), 128'(0));
      return;
    end
    r = exp_q.pop_front();
    chk({tag, "_mask"}, 128'(SET_CONFIG_CH), 128'(r.mask));
    for (int i = 0; i < 4; i++)
      if (r.mask[i]) chk($sformatf("%s_ch%0d", tag, i), 128'(slice(i)), 128'(r.cfg));
  endtask
  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, 128'({SET_CONFIG_CH, STOP_CH, BUSY, CONFIG_DONE, CONFIG_CLAMPED}), 128'(0));
    chk({tag, "_slices"}, 128'(|{ACQUIRE_MODE_CH, TRIGGER_TYPE_CH, RISING_EDGE_THRESHOLD_CH,
        FALLING_EDGE_THRESHOLD_CH, L_GAIN_BASELINE_CH, H_GAIN_BASELINE_CH, PRE_ACQUISITION_LENGTH_CH,
        POST_ACQUISITION_LENGTH_CH, MAX_TRIGGER_LENGTH_CH}), 128'(0));
  endtask
  initial begin
    cfg_t a = '{2'd1, 4'd3, 16'd200, -16'sd50, 16'd1000, -13'sd100, 2'd1, 2'd2, 16'd100};
    cfg_t b = '{2'd2, 4'd5, 16'd300, 16'd10, -16'sd7, 13'sd55, 2'd0, 2'd1, 16'd42};
    cfg_t c = '{2'd3, 4'd9, -16'sd10, 16'sd5, 16'd77, 13'sd1, 2'd3, 2'd3, 16'd0};
    cfg_t d = '{2'd0, 4'd1, 16'd500, 16'd400, 16'd123, -13'sd4096, 2'd2, 2'd0, 16'd9};
    cfg_t e = '{2'd1, 4'd15, 16'd60, -16'sd60, 16'd8, 13'sd4095, 2'd1, 2'd1, 16'hFFFF};
    cfg_t f = '{2'd2, 4'd2, 16'd11, 16'd11, 16'd22, 13'sd33, 2'd0, 2'd2, 16'd44};
    cfg_t g = '{2'd3, 4'd6, 16'd90, 16'd80, 16'd70, 13'sd60, 2'd1, 2'd0, 16'd50};
    cfg_t h = '{2'd0, 4'd12, -16'sd100, -16'sd200, 16'd5, -13'sd5, 2'd2, 2'd2, 16'd3};
    cfg_t k = '{2'd1, 4'd7, 16'd1, 16'd0, 16'd2, 13'sd3, 2'd1, 2'd1, 16'd4};
    cfg_t j = '{2'd2, 4'd8, 16'd1234, 16'd234, 16'd34, 13'sd4, 2'd0, 2'd0, 16'd5};
    @(negedge CLK);
    @(negedge CLK);
    check_all_zero("reset");
    RESETN = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    // 1: basic update to all channels
    apply(a);
    CHANNEL_ENABLE = 4'hF;
    expect_commit(4'hF, a);
    SET_CONFIG = 1'b1;
    @(negedge CLK);
    chk("t1_busy", 128'(BUSY), 128'(1));
    SET_CONFIG = 1'b0;
    check_commit("t1", 2);
    chk("t1_done_early", 128'(CONFIG_DONE), 128'(0));
    @(negedge CLK);
    chk("t1_done", 128'(CONFIG_DONE), 128'(1));
    chk("t1_clamped", 128'(CONFIG_CLAMPED), 128'(0));
    @(negedge CLK);
    chk("t1_done_pulse", 128'({CONFIG_DONE, BUSY}), 128'(0));
    // 2: channel 2 busy for a while
    apply(b);
    CH_BUSY = 4'b0100;
    expect_commit(4'b1011, b);
    expect_commit(4'b0100, b);
    SET_CONFIG = 1'b1;
    @(negedge CLK);
    SET_CONFIG = 1'b0;
    check_commit("t2a", 2);
    chk("t2_ch2_old", 128'(slice(2)), 128'(clampf(a)));
    for (int i = 3; i <= 5; i++) begin
      @(negedge CLK);
      chk($sformatf("t2_wait%0d", i), 128'({SET_CONFIG_CH, BUSY, CONFIG_DONE}), 128'(5'b00010));
    end
    CH_BUSY = 4'b0000;
    check_commit("t2b", 1);
    @(negedge CLK);
    chk("t2_done", 128'(CONFIG_DONE), 128'(1));
    // 3: clamping, then a clean update clears the flag
    apply(c);
    expect_commit(4'hF, c);
    SET_CONFIG = 1'b1;
    @(negedge CLK);
    SET_CONFIG = 1'b0;
    check_commit("t3", 2);
    chk("t3_pre", 128'(PRE_ACQUISITION_LENGTH_CH[1:0]), 128'(2));
    chk("t3_mtl", 128'(MAX_TRIGGER_LENGTH_CH[15:0]), 128'(1));
    chk("t3_fall", 128'(FALLING_EDGE_THRESHOLD_CH[15:0]), 128'(16'hFFF6));
    @(negedge CLK);
    chk("t3_done", 128'(CONFIG_DONE), 128'(1));
    chk("t3_clamped", 128'(CONFIG_CLAMPED), 128'(1));
    apply(d);
    expect_commit(4'hF, d);
    SET_CONFIG = 1'b1;
    @(negedge CLK);
    SET_CONFIG = 1'b0;
    check_commit("t3c", 2);
    @(negedge CLK);
    chk("t3c_clamped", 128'({CONFIG_DONE, CONFIG_CLAMPED}), 128'(2'b10));
    // 4: partial enable mask and STOP fan-out
    apply(e);
    CHANNEL_ENABLE = 4'b0011;
    expect_commit(4'b0011, e);
    SET_CONFIG = 1'b1;
    @(negedge CLK);
    SET_CONFIG = 1'b0;
    check_commit("t4", 2);
    chk("t4_ch2_keep", 128'(slice(2)), 128'(clampf(d)));
    chk("t4_ch3_keep", 128'(slice(3)), 128'(clampf(d)));
    @(negedge CLK);
    chk("t4_done", 128'(CONFIG_DONE), 128'(1));
    STOP = 1'b1;
    @(negedge CLK);
    chk("t4_stop", 128'(STOP_CH), 128'(4'b0011));
    STOP = 1'b0;
    @(negedge CLK);
    chk("t4_stop_off", 128'(STOP_CH), 128'(0));
    // 5a: STOP aborts a distribution held by a busy channel
    apply(f);
    CHANNEL_ENABLE = 4'hF;
    CH_BUSY = 4'b1000;
    expect_commit(4'b0111, f);
    SET_CONFIG = 1'b1;
    @(negedge CLK);
    SET_CONFIG = 1'b0;
    check_commit("t5a", 2);
    STOP = 1'b1;
    @(negedge CLK);
    chk("t5a_abort", 128'({BUSY, CONFIG_DONE, STOP_CH}), 128'(6'b001111));
    STOP = 1'b0;
    CH_BUSY = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("t5a_quiet%0d", i), 128'({SET_CONFIG_CH, BUSY, CONFIG_DONE}), 128'(0));
    end
    chk("t5a_ch3_keep", 128'(slice(3)), 128'(clampf(d)));
    // 5b: a new edge during DIST recaptures and recommits everything
    apply(g);
    CH_BUSY = 4'b1000;
    expect_commit(4'b0111, g);
    SET_CONFIG = 1'b1;
    @(negedge CLK);
    SET_CONFIG = 1'b0;
    check_commit("t5b1", 2);
    apply(h);
    CH_BUSY = 4'b0000;
    expect_commit(4'hF, h);
    SET_CONFIG = 1'b1;
    @(negedge CLK);
    chk("t5b_restart", 128'({SET_CONFIG_CH, BUSY, CONFIG_DONE}), 128'(6'b000010));
    SET_CONFIG = 1'b0;
    check_commit("t5b2", 2);
    @(negedge CLK);
    chk("t5b_done", 128'(CONFIG_DONE), 128'(1));
    // 6: asynchronous reset mid-distribution, SET_CONFIG held across reset
    apply(k);
    CH_BUSY = 4'b0100;
    expect_commit(4'b1011, k);
    SET_CONFIG = 1'b1;
    @(negedge CLK);
    check_commit("t6", 2);
    #2 RESETN = 1'b0;
    #1 check_all_zero("t6_async");
    @(negedge CLK);
    RESETN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk($sformatf("t6_hold%0d", i), 128'({SET_CONFIG_CH, BUSY}), 128'(0));
    end
    SET_CONFIG = 1'b0;
    CH_BUSY = 4'b0000;
    @(negedge CLK);
    @(negedge CLK);
    apply(j);
    expect_commit(4'hF, j);
    SET_CONFIG = 1'b1;
    @(negedge CLK);
    SET_CONFIG = 1'b0;
    check_commit("t6b", 2);
    @(negedge CLK);
    chk("t6b_done", 128'(CONFIG_DONE), 128'(1));
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
